// File: rtl/stage_sequencer.sv
// stage_sequencer: runs NUM_STAGES processing stages in order over a shared edge BRAM
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   run, stage_count      level run request and number of stages (clamped to NUM_STAGES)
//   abort                 abandon the current run and return to idle
//   stage_start/done      one-hot start pulse out, per-stage completion in
//   stage_addra/dina/wea  flattened per-slot BRAM port-A write buses
//   stage_addrb           flattened per-slot BRAM port-B read addresses
//   display_addr          VGA playback read address, owns port B when idle
//   bram_*                steered BRAM ports
//   busy, done, error     status; cur_stage is the active or last stage index
module stage_sequencer #(
    parameter int NUM_STAGES = 4,
    parameter int ADDR_W = 19,
    parameter int DATA_W = 3,
    parameter int TIMEOUT_W = 24,
    localparam int CNT_W = $clog2(NUM_STAGES + 1),
    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         run,
    input  logic [CNT_W-1:0]             stage_count,
    input  logic                         abort,
    output logic [NUM_STAGES-1:0]        stage_start,
    input  logic [NUM_STAGES-1:0]        stage_done,
    input  logic [NUM_STAGES*ADDR_W-1:0] stage_addra,
    input  logic [NUM_STAGES*DATA_W-1:0] stage_dina,
    input  logic [NUM_STAGES-1:0]        stage_wea,
    input  logic [NUM_STAGES*ADDR_W-1:0] stage_addrb,
    input  logic [ADDR_W-1:0]            display_addr,
    output logic [ADDR_W-1:0]            bram_addra,
    output logic [DATA_W-1:0]            bram_dina,
    output logic                         bram_wea,
    output logic [ADDR_W-1:0]            bram_addrb,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic [IDX_W-1:0]             cur_stage
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_DONE, S_ERROR} state_t;
    state_t state;
    logic [IDX_W-1:0] last;
    logic [TIMEOUT_W-1:0] wd;
    logic [CNT_W-1:0] n_clamp;
    logic [IDX_W-1:0] next_idx;
    logic wd_expire;
    logic active;
    logic [ADDR_W-1:0] slot_addra [NUM_STAGES];
    logic [ADDR_W-1:0] slot_addrb [NUM_STAGES];
    logic [DATA_W-1:0] slot_dina [NUM_STAGES];
    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_slot
        assign slot_addra[i] = stage_addra[i*ADDR_W +: ADDR_W];
        assign slot_addrb[i] = stage_addrb[i*ADDR_W +: ADDR_W];
        assign slot_dina[i]  = stage_dina[i*DATA_W +: DATA_W];
    end
    assign n_clamp  = (stage_count > CNT_W'(NUM_STAGES)) ? CNT_W'(NUM_STAGES) : stage_count;
    assign next_idx = cur_stage + IDX_W'(1);
    // The count is compared before incrementing, so the trip value is one short of all-ones;
    // that places error exactly 2^TIMEOUT_W cycles after the start pulse.
    assign wd_expire = (wd == {{(TIMEOUT_W-1){1'b1}}, 1'b0});
    assign active = (state == S_START) || (state == S_WAIT);
    assign bram_addra = active ? slot_addra[cur_stage] : '0;
    assign bram_dina  = active ? slot_dina[cur_stage] : '0;
    assign bram_wea   = active ? stage_wea[cur_stage] : 1'b0;
    assign bram_addrb = active ? slot_addrb[cur_stage] : display_addr;
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            stage_start <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            cur_stage   <= '0;
            last        <= '0;
            wd          <= '0;
        end else if (abort) begin
            state       <= S_IDLE;
            stage_start <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            wd          <= '0;
        end else begin
            stage_start <= '0;
            case (state)
                S_IDLE: begin
                    if (run) begin
                        cur_stage <= '0;
                        last      <= IDX_W'(n_clamp - CNT_W'(1));
                        if (n_clamp == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state       <= S_START;
                            stage_start <= NUM_STAGES'(1);
                            busy        <= 1'b1;
                        end
                    end
                end
                S_START: begin
                    state <= S_WAIT;
                    wd    <= '0;
                end
                S_WAIT: begin
                    if (stage_done[cur_stage]) begin
                        if (cur_stage == last) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state       <= S_START;
                            cur_stage   <= next_idx;
                            stage_start <= NUM_STAGES'(1) << next_idx;
                        end
                    end else begin
                        wd <= wd + TIMEOUT_W'(1);
                        if (wd_expire) begin
                            state <= S_ERROR;
                            busy  <= 1'b0;
                            error <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (!run) begin
                        state <= S_IDLE;
                        done  <= 1'b0;
                    end
                end
                S_ERROR: state <= S_ERROR;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
